writeback_arbiter: RTL
======================

// Module: writeback_arbiter
// PURPOSE
//   Writeback stage directly upstream of register_file. Merges two result sources into the
//   register file's single write port (writen_en / write_address / data_in):
//   - in-order ALU results;
//   - out-of-band load returns from the data memory, buffered in a small FIFO.
//   Registered outputs drive the write port. Writes to r0 are never issued.
// PARAMETERS
//   DATA_W    64  datapath width, matches register file entries
//   ADDR_W    5   register index width (32 registers)
//   LQ_DEPTH  4   load-return FIFO entries, power of two, >= 2
// PORTS
//   clk        in   1          clock
//   reset      in   1          synchronous, active-high
//   alu_valid  in   1          ALU result offered this cycle
//   alu_ready  out  1          ALU result accepted when alu_valid && alu_ready
//   alu_wen    in   1          result targets a register (0 = store/nop, consumes no write slot)
//   alu_rd     in   ADDR_W     ALU destination register
//   alu_data   in   DATA_W     ALU result
//   ld_valid   in   1          load return offered
//   ld_ready   out  1          load return accepted when ld_valid && ld_ready
//   ld_rd      in   ADDR_W     load destination register
//   ld_data    in   DATA_W     load data
//   wb_en      out  1          to register_file writen_en
//   wb_addr    out  ADDR_W     to register_file write_address
//   wb_data    out  DATA_W     to register_file data_in
//   lq_count   out  $clog2(LQ_DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//   - Reset (sync, active-high): FIFO emptied, pending loads dropped; last_grant=LOAD;
//     next cycle wb_en=0, wb_addr=0, wb_data=0, lq_count=0. Reset mid-operation behaves the same.
//   - Load path: push on ld_valid && ld_ready; ld_ready = (lq_count != LQ_DEPTH), registered
//     state only. No combinational path from ld_valid.
//   - No bypass: a load pushed into an empty FIFO earliest raises wb_en 2 cycles after acceptance.
//   - Write-slot arbitration, once per cycle, between the FIFO head and the ALU (alu_valid && alu_wen):
//     - only one requests -> it wins;
//     - both request and FIFO full -> FIFO wins;
//     - both request otherwise -> round-robin vs last_grant (last LOAD -> ALU wins, and vice versa).
//     - last_grant updates only on contended cycles.
//   - alu_ready = 1 unless alu_wen && the FIFO wins this cycle.
//   - alu_wen=0 results are always accepted and never block a same-cycle FIFO pop.
//   - Winner drives the write-port registers at the clock edge: wb_en=1, wb_addr=rd, wb_data=data.
//     Latency for a winning ALU result is 1 cycle. With no winner, next cycle wb_en=0 and
//     wb_addr/wb_data hold their previous values.
//   - r0 rule: a winner with rd==0 is consumed (ALU accepted / FIFO popped) but wb_en=0.
//     This is mandatory because register_file bypasses write data onto reads of the same
//     address, r0 included.
//   - Push and pop in the same cycle: lq_count unchanged.
//     Push while full: impossible, because ld_ready=0.
//   - FIFO pointers wrap modulo LQ_DEPTH. Loads retire in arrival order.
//     There is no ordering between the ALU and load streams; the issue stage guarantees no
//     WAW hazard between them.
// TESTING
//   1. ALU only: alu_valid=1, wen=1, rd=3, data=64'hA5 -> next cycle wb_en=1, addr=3, data=A5; alu_ready stays 1.
//   2. Load only: ld rd=7, data=64'h1234 accepted at cycle t -> wb_en=1, addr=7 at t+2; lq_count 1 then 0.
//   3. Contention: FIFO holds 2 loads, ALU streaming wen=1 -> writes alternate ALU, LD, ALU, LD;
//      alu_ready=0 on the LD cycles.
//   4. Full: 4 loads pushed while the ALU holds the slot -> ld_ready=0 at lq_count=4;
//      the next write is from the FIFO even if the ALU won last.
//   5. r0: ALU rd=0 and load rd=0 -> both consumed, wb_en never 1, lq_count returns to 0.
//   6. Reset with 3 loads queued -> next cycle lq_count=0, wb_en=0, ld_ready=1;
//      the dropped loads are never written.

Source files
------------

// File: rtl/writeback_arbiter.sv
// Writeback stage: merges in-order ALU results and buffered load returns onto the
// register file's single write port, with round-robin arbitration and r0 suppression.
module writeback_arbiter #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned LQ_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alu_valid,
  output logic                          alu_ready,
  input  logic                          alu_wen,
  input  logic [ADDR_W-1:0]             alu_rd,
  input  logic [DATA_W-1:0]             alu_data,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic [ADDR_W-1:0]             ld_rd,
  input  logic [DATA_W-1:0]             ld_data,
  output logic                          wb_en,
  output logic [ADDR_W-1:0]             wb_addr,
  output logic [DATA_W-1:0]             wb_data,
  output logic [$clog2(LQ_DEPTH):0]     lq_count
);

  localparam int unsigned PTR_W = $clog2(LQ_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LQ_DEPTH);

  typedef enum logic {
    GRANT_ALU  = 1'b0,
    GRANT_LOAD = 1'b1
  } grant_t;

  logic [ADDR_W-1:0] rd_mem   [LQ_DEPTH];
  logic [DATA_W-1:0] data_mem [LQ_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  grant_t            last_grant;

  logic fifo_full, fifo_req, alu_req, contended;
  logic fifo_win, alu_win, push, pop;

  always_comb begin
    fifo_full = (count == FULL_CNT);
    fifo_req  = (count != '0);
    alu_req   = alu_valid && alu_wen;
    contended = fifo_req && alu_req;
    // A full FIFO overrides round-robin so load returns can never be starved.
    fifo_win  = fifo_req && (!alu_req || fifo_full || (last_grant == GRANT_ALU));
    alu_win   = alu_req && !fifo_win;
    ld_ready  = !fifo_full;
    alu_ready = !(alu_wen && fifo_win);
    push      = ld_valid && ld_ready;
    pop       = fifo_win;
    lq_count  = count;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr]   <= ld_rd;
      data_mem[wr_ptr] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_grant <= GRANT_LOAD;
      wb_en      <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (contended) last_grant <= fifo_win ? GRANT_LOAD : GRANT_ALU;
      // r0 winners are consumed but never reach the port; address/data then hold.
      wb_en <= 1'b0;
      if (fifo_win) begin
        if (rd_mem[rd_ptr] != '0) begin
          wb_en   <= 1'b1;
          wb_addr <= rd_mem[rd_ptr];
          wb_data <= data_mem[rd_ptr];
        end
      end else if (alu_win) begin
        if (alu_rd != '0) begin
          wb_en   <= 1'b1;
          wb_addr <= alu_rd;
          wb_data <= alu_data;
        end
      end
    end
  end

endmodule
